// File: rtl/wbn_pkg.sv
// wbn_pkg: shared state type, default widths and the round-robin helper
// used by the Wishbone arbiter family.
package wbn_pkg;

  localparam int WBN_AW_DEF = 32;
  localparam int WBN_DW_DEF = 32;
  // Largest master count the round-robin helper can scan.
  localparam int WBN_MAX_N  = 32;
  localparam int WBN_IDX_W  = $clog2(WBN_MAX_N);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } wbn_state_e;

  typedef struct packed {
    logic                 vld;
    logic [WBN_IDX_W-1:0] idx;
  } wbn_pick_t;

  // First requester found scanning last+1, last+2, ... modulo n.
  function automatic wbn_pick_t wbn_rr_next(input logic [WBN_MAX_N-1:0] req,
                                            input int n, input int last);
    wbn_pick_t pick;
    int        cand;
    pick = '0;
    for (int k = 1; k <= WBN_MAX_N; k++) begin
      cand = (last + k) % n;
      if (k <= n && !pick.vld && req[cand[WBN_IDX_W-1:0]]) begin
        pick.vld = 1'b1;
        pick.idx = cand[WBN_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wbn_rr_pick.sv
// wbn_rr_pick: combinational round-robin picker. Given N request bits and the
// index granted last, returns the next index to grant and whether any exists.
module wbn_rr_pick import wbn_pkg::*; #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vld
);

  localparam int IW = $clog2(N);

  logic [WBN_MAX_N-1:0] req_ext;
  wbn_pick_t            pick;
  // Folds the index bits beyond N so every bit of the helper result is consumed.
  logic                 pick_unused;

  // Widen the request vector to the helper's width and scan it.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = wbn_rr_next(req_ext, N, int'(last));
  end

  assign vld         = pick.vld;
  assign idx         = pick.idx[IW-1:0];
  assign pick_unused = ^pick.idx;

endmodule

// File: rtl/wbn_arbiter.sv
// wbn_arbiter: N-master to 1-slave classic Wishbone arbiter. Round-robin
// grant, bus held for the owner's whole cyc, combinational request and
// response paths while busy. Define WBN_ARBITER_TIMEOUT_EN to add a watchdog
// that answers a transfer stalled for TO cycles with err.
module wbn_arbiter import wbn_pkg::*; #(
  parameter int N  = 2,
  parameter int AW = WBN_AW_DEF,
  parameter int DW = WBN_DW_DEF,
  parameter int SW = DW / 8,
  parameter int TO = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         m_cyc,
  input  logic [N-1:0]         m_we,
  input  logic [N-1:0]         m_stb,
  input  logic [N-1:0][AW-1:0] m_adr,
  input  logic [N-1:0][SW-1:0] m_sel,
  input  logic [N-1:0][DW-1:0] m_dat_w,
  output logic [DW-1:0]        m_dat_r,
  output logic [N-1:0]         m_ack,
  output logic [N-1:0]         m_err,
  output logic [N-1:0]         m_rty,
  output logic                 s_cyc,
  output logic                 s_we,
  output logic                 s_stb,
  output logic [AW-1:0]        s_adr,
  output logic [SW-1:0]        s_sel,
  output logic [DW-1:0]        s_dat_w,
  input  logic [DW-1:0]        s_dat_r,
  input  logic                 s_ack,
  input  logic                 s_err,
  input  logic                 s_rty
);

  localparam int IW = $clog2(N);

  wbn_state_e    state, state_nxt;
  logic [IW-1:0] own, own_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          to_fire;

  wbn_rr_pick #(.N(N)) u_pick (
    .req  (m_cyc),
    .last (last),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  // Arbitration state; last starts at N-1 so master 0 wins first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      own   <= '0;
      last  <= IW'(N - 1);
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      last  <= last_nxt;
    end
  end

  // Grant from idle, or on the owner's release hand straight to the next requester.
  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_BUSY;
          own_nxt   = pick_idx;
          last_nxt  = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!m_cyc[own]) begin
          if (pick_vld) begin
            own_nxt  = pick_idx;
            last_nxt = pick_idx;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Slave request follows the owner while busy and is quiet otherwise.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    if (state == ST_BUSY) begin
      s_cyc   = m_cyc[own];
      s_stb   = m_stb[own];
      s_we    = m_we[own];
      s_adr   = m_adr[own];
      s_sel   = m_sel[own];
      s_dat_w = m_dat_w[own];
    end
  end

  // Route slave terminations to the owner only while its cycle is on the bus.
  always_comb begin
    m_ack = '0;
    m_err = '0;
    m_rty = '0;
    if (s_cyc) begin
      m_ack[own] = s_ack & ~to_fire;
      m_err[own] = s_err | to_fire;
      m_rty[own] = s_rty & ~to_fire;
    end
  end

  assign m_dat_r = s_dat_r;

`ifdef WBN_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TO);

  logic [CW-1:0] to_cnt;
  logic          xfer;
  logic          term;

  assign xfer    = s_cyc & s_stb;
  assign term    = s_ack | s_err | s_rty;
  assign to_fire = xfer && (to_cnt == CW'(TO - 1));

  // Count stalled strobe cycles; any termination, idle strobe or firing restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (!xfer || term || to_fire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wbn_arbiter.sv
// tb_wbn_arbiter: directed scenarios plus randomized traffic for wbn_arbiter,
// every cycle compared against a behavioural model of the grant rules.
`timescale 1ns/1ps
module tb_wbn_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
  localparam int IW = $clog2(N);
`ifdef WBN_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         m_cyc, m_we, m_stb;
  logic [N-1:0][AW-1:0] m_adr;
  logic [N-1:0][SW-1:0] m_sel;
  logic [N-1:0][DW-1:0] m_dat_w;
  logic [DW-1:0]        m_dat_r;
  logic [N-1:0]         m_ack, m_err, m_rty;
  logic                 s_cyc, s_we, s_stb;
  logic [AW-1:0]        s_adr;
  logic [SW-1:0]        s_sel;
  logic [DW-1:0]        s_dat_w;
  logic [DW-1:0]        s_dat_r;
  logic                 s_ack, s_err, s_rty;

  wbn_arbiter #(.N(N), .AW(AW), .DW(DW), .SW(SW), .TO(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_we(m_we), .m_stb(m_stb),
    .m_adr(m_adr), .m_sel(m_sel), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_we(s_we), .s_stb(s_stb),
    .s_adr(s_adr), .s_sel(s_sel), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: owner index (-1 when nobody owns the bus), index granted
  // last, and how many stalled strobe cycles the owner has already waited.
  int mown, mlast, mpend;

  function automatic int rr_scan(input logic [N-1:0] req, input int from);
    for (int k = 1; k <= N; k++)
      if (req[IW'((from + k) % N)]) return (from + k) % N;
    return -1;
  endfunction

  function automatic bit model_fire();
    if (!TO_EN || mown < 0) return 1'b0;
    return m_cyc[IW'(mown)] && m_stb[IW'(mown)] && (mpend == TO - 1);
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[IW'(i)]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mown  <= -1;
      mlast <= N - 1;
      mpend <= 0;
    end else begin
      if (mown >= 0 && m_cyc[IW'(mown)] && m_stb[IW'(mown)] &&
          !(s_ack || s_err || s_rty) && !model_fire())
        mpend <= mpend + 1;
      else
        mpend <= 0;
      if (mown < 0 || !m_cyc[IW'(mown)]) begin
        if (rr_scan(m_cyc, mlast) >= 0) begin
          mown  <= rr_scan(m_cyc, mlast);
          mlast <= rr_scan(m_cyc, mlast);
        end else begin
          mown <= -1;
        end
      end
    end
  end

  task automatic model_check();
    logic          e_cyc, e_stb, e_we, fire;
    logic [AW-1:0] e_adr;
    logic [SW-1:0] e_sel;
    logic [DW-1:0] e_dat;
    logic [N-1:0]  e_ack, e_err, e_rty;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; fire = 1'b0;
    e_adr = '0; e_sel = '0; e_dat = '0;
    e_ack = '0; e_err = '0; e_rty = '0;
    if (rst && mown >= 0) begin
      e_cyc = m_cyc[IW'(mown)];
      e_stb = m_stb[IW'(mown)];
      e_we  = m_we[IW'(mown)];
      e_adr = m_adr[IW'(mown)];
      e_sel = m_sel[IW'(mown)];
      e_dat = m_dat_w[IW'(mown)];
      fire  = model_fire();
      if (e_cyc) begin
        e_ack[IW'(mown)] = s_ack && !fire;
        e_err[IW'(mown)] = s_err || fire;
        e_rty[IW'(mown)] = s_rty && !fire;
      end
    end
    check("ctl", {s_cyc, s_stb, s_we}, {e_cyc, e_stb, e_we});
    check("adr", s_adr, e_adr);
    check("sel", s_sel, e_sel);
    check("dat_w", s_dat_w, e_dat);
    check("term", {m_ack, m_err, m_rty}, {e_ack, e_err, e_rty});
    check("dat_r", m_dat_r, s_dat_r);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    nxt();
    sample();
    nxt();
    rst = 1'b1;
  endtask

  int grants[$];
  int gaps[$];
  int errs[$];
  int exp_rr[4] = '{0, 1, 2, 0};
  int drop, back, gap, t0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state with every master and the slave shouting.
    rst = 1'b0;
    m_cyc = '1; m_stb = '1; m_we = '1;
    m_adr = '0; m_sel = '0; m_dat_w = '0;
    m_adr[0] = 16'h1111; m_sel[0] = 4'hF; m_dat_w[0] = 32'hCAFE_0000;
    s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1; s_dat_r = 32'h1234_5678;
    sample();
    check("rst_ctl", {s_cyc, s_stb, s_we}, 3'b000);
    check("rst_adr", {s_adr, s_sel}, 0);
    check("rst_term", {m_ack, m_err, m_rty}, 0);
    check("rst_dat_r", m_dat_r, 32'h1234_5678);
    nxt();
    rst = 1'b1;
    idle_inputs();
    sample();

    // Single master 1 read at 0x100, slave answers after two wait cycles.
    nxt();
    m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b000;
    m_adr[1] = 16'h0100; m_sel[1] = 4'hF;
    sample();
    check("sm_wait", s_cyc, 1'b0);
    nxt();
    sample();
    check("sm_grant", {s_cyc, s_stb, s_we, s_adr}, {3'b110, 16'h0100});
    nxt();
    sample();
    nxt();
    s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
    sample();
    check("sm_ack", m_ack, 3'b010);
    check("sm_dat_r", m_dat_r, 32'hDEAD_BEEF);
    nxt();
    idle_inputs();
    sample();
    check("sm_release", s_cyc, 1'b0);

    // Stray responses while idle.
    nxt();
    s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
    sample();
    check("stray", {m_ack, m_err, m_rty}, 0);
    nxt();
    idle_inputs();
    sample();

    // Round robin: everyone requests, one transfer per grant, requester returns a cycle later.
    do_reset();
    for (int i = 0; i < N; i++) m_adr[IW'(i)] = AW'(16'h0200 + 16'(i * 16));
    m_cyc = '1; m_stb = '1; s_ack = 1'b1;
    drop = -1; back = -1; gap = 0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      sample();
      if (m_ack != '0) begin
        grants.push_back(onehot_idx(m_ack));
        if (grants.size() > 1) gaps.push_back(gap);
        gap  = 0;
        drop = onehot_idx(m_ack);
      end else if (!s_cyc && grants.size() > 0) begin
        gap++;
      end
      nxt();
      if (back >= 0) begin m_cyc[IW'(back)] = 1'b1; m_stb[IW'(back)] = 1'b1; back = -1; end
      if (drop >= 0) begin m_cyc[IW'(drop)] = 1'b0; m_stb[IW'(drop)] = 1'b0; back = drop; drop = -1; end
    end
    check("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) check($sformatf("rr_grant%0d", i), grants[i], exp_rr[i]);
    for (int i = 0; i < gaps.size(); i++) check($sformatf("rr_gap%0d", i), gaps[i], 1);
    idle_inputs();
    sample();
    nxt();
    sample();

    // Cycle lock: master 0 block write of 4 beats while master 1 waits.
    nxt();
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b001;
    m_adr[0] = 16'h0A00; m_dat_w[0] = $urandom;
    sample();
    nxt();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 16'h0B00; s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      sample();
      check($sformatf("lock_beat%0d", b), {s_cyc, s_adr, m_ack}, {1'b1, 16'h0A00 + 16'(4 * b), 3'b001});
      nxt();
      m_adr[0] = m_adr[0] + 16'h0004;
      m_dat_w[0] = $urandom;
      if (b == 3) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0; end
    end
    sample();
    check("lock_gap", s_cyc, 1'b0);
    nxt();
    sample();
    check("lock_g1", {s_cyc, s_adr}, {1'b1, 16'h0B00});
    nxt();
    idle_inputs();
    sample();

    // Reset while master 2 is mid-transfer with the others waiting.
    nxt();
    m_cyc = 3'b100; m_stb = 3'b100; m_adr[2] = 16'h0C00;
    sample();
    nxt();
    m_cyc = 3'b111; m_stb = 3'b111; m_adr[0] = 16'h0D00;
    sample();
    check("rst_pre", {s_cyc, s_stb, s_adr}, {2'b11, 16'h0C00});
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", {s_cyc, s_stb}, 2'b00);
    check("rst_async_term", {m_ack, m_err, m_rty}, 0);
    nxt();
    rst = 1'b1;
    sample();
    nxt();
    sample();
    check("rst_prio", {s_cyc, s_adr}, {1'b1, 16'h0D00});

`ifdef WBN_ARBITER_TIMEOUT_EN
    // Watchdog: slave never answers, strobe held.
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001; m_adr[0] = 16'h0E00;
    t0 = -1;
    for (int c = 0; c < 24; c++) begin
      sample();
      if (t0 < 0 && s_stb) t0 = c;
      if (m_err[0] && t0 >= 0) errs.push_back(c - t0);
      nxt();
    end
    check("to_count", errs.size(), 2);
    for (int i = 0; i < errs.size(); i++) check($sformatf("to_err%0d", i), errs[i], (TO - 1) + TO * i);
    idle_inputs();
`endif

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_cyc[IW'(i)]) begin
          if ($urandom_range(0, 5) == 0) m_cyc[IW'(i)] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          m_cyc[IW'(i)] = 1'b1;
        end
        m_stb[IW'(i)]   = m_cyc[IW'(i)] & ($urandom_range(0, 3) != 0);
        m_we[IW'(i)]    = 1'($urandom);
        m_adr[IW'(i)]   = AW'($urandom);
        m_sel[IW'(i)]   = SW'($urandom);
        m_dat_w[IW'(i)] = DW'($urandom);
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 15) == 0);
      s_rty   = ($urandom_range(0, 15) == 0);
      s_dat_r = DW'($urandom);
      sample();
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
